// File: rtl/io_uart_bridge.sv
// Byte-stream to 8N1 UART bridge: TX FIFO feeding a serializer, and a
// synchronized deserializer feeding a first-word-fallthrough RX FIFO.
module io_uart_bridge #(
    parameter int CLK_DIV    = 868,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] io_o_data,
    input  logic       io_o_valid,
    output logic       io_o_ready,
    output logic [7:0] io_i_data,
    output logic       io_i_valid,
    input  logic       io_i_ready,
    output logic       uart_txd,
    input  logic       uart_rxd,
    output logic       rx_overrun,
    output logic       rx_frame_err
);
    localparam int          AW          = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT    = (AW+1)'(FIFO_DEPTH);
    localparam logic [15:0] BIT_RELOAD  = 16'(CLK_DIV - 1);
    localparam logic [15:0] HALF_RELOAD = 16'(CLK_DIV / 2 - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    // ---------------- TX FIFO ----------------
    logic [7:0]    tx_mem [FIFO_DEPTH];
    logic [AW-1:0] tx_wr, tx_rd;
    logic [AW:0]   tx_cnt, tx_cnt_nxt;
    logic          tx_push, tx_pop;

    assign tx_push = io_o_valid && io_o_ready;

    always_comb begin
        tx_cnt_nxt = tx_cnt;
        if (tx_push && !tx_pop)
            tx_cnt_nxt = tx_cnt + 1'b1;
        else if (!tx_push && tx_pop)
            tx_cnt_nxt = tx_cnt - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (tx_push)
            tx_mem[tx_wr] <= io_o_data;
    end

    // Ready is registered from the next occupancy, so a pop frees a slot
    // only from the following cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_wr      <= '0;
            tx_rd      <= '0;
            tx_cnt     <= '0;
            io_o_ready <= 1'b0;
        end else begin
            if (tx_push)
                tx_wr <= tx_wr + 1'b1;
            if (tx_pop)
                tx_rd <= tx_rd + 1'b1;
            tx_cnt     <= tx_cnt_nxt;
            io_o_ready <= (tx_cnt_nxt != FULL_CNT);
        end
    end

    // ---------------- TX serializer ----------------
    state_t      tx_state;
    logic [15:0] tx_tmr;
    logic [2:0]  tx_bit;
    logic [7:0]  tx_sh;
    logic        tx_done;

    assign tx_done = (tx_tmr == '0);
    assign tx_pop  = (tx_cnt != '0) &&
                     (tx_state == IDLE || (tx_state == STOP && tx_done));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state <= IDLE;
            tx_tmr   <= '0;
            tx_bit   <= '0;
            tx_sh    <= '0;
            uart_txd <= 1'b1;
        end else begin
            if (!tx_done)
                tx_tmr <= tx_tmr - 1'b1;
            if (tx_pop) begin
                // Covers both idle start and back-to-back chaining out of STOP
                tx_sh    <= tx_mem[tx_rd];
                tx_state <= START;
                tx_tmr   <= BIT_RELOAD;
                uart_txd <= 1'b0;
            end else begin
                case (tx_state)
                    START: if (tx_done) begin
                        tx_state <= DATA;
                        tx_tmr   <= BIT_RELOAD;
                        tx_bit   <= '0;
                        uart_txd <= tx_sh[0];
                    end
                    DATA: if (tx_done) begin
                        tx_tmr <= BIT_RELOAD;
                        if (tx_bit == 3'd7) begin
                            tx_state <= STOP;
                            uart_txd <= 1'b1;
                        end else begin
                            tx_bit   <= tx_bit + 1'b1;
                            tx_sh    <= {1'b0, tx_sh[7:1]};
                            uart_txd <= tx_sh[1];
                        end
                    end
                    STOP: if (tx_done) begin
                        tx_state <= IDLE;
                        uart_txd <= 1'b1;
                    end
                    default: uart_txd <= 1'b1;
                endcase
            end
        end
    end

    // ---------------- RX synchronizer ----------------
    logic [1:0] rx_sync;
    logic       rx_s, rx_prev;

    assign rx_s = rx_sync[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_sync <= 2'b11;
            rx_prev <= 1'b1;
        end else begin
            rx_sync <= {rx_sync[0], uart_rxd};
            rx_prev <= rx_s;
        end
    end

    // ---------------- RX deserializer ----------------
    state_t        rx_state;
    logic [15:0]   rx_tmr;
    logic [2:0]    rx_bit;
    logic [7:0]    rx_sh;
    logic          rx_done, rx_stop_hit, rx_push, rx_pop;
    logic [7:0]    rx_mem [FIFO_DEPTH];
    logic [AW-1:0] rx_wr, rx_rd;
    logic [AW:0]   rx_cnt;

    assign rx_done     = (rx_tmr == '0);
    assign rx_stop_hit = (rx_state == STOP) && rx_done;
    assign rx_pop      = io_i_valid && io_i_ready;
    assign rx_push     = rx_stop_hit && rx_s && (rx_cnt != FULL_CNT || rx_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state     <= IDLE;
            rx_tmr       <= '0;
            rx_bit       <= '0;
            rx_sh        <= '0;
            rx_overrun   <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            rx_overrun   <= 1'b0;
            rx_frame_err <= 1'b0;
            if (!rx_done)
                rx_tmr <= rx_tmr - 1'b1;
            case (rx_state)
                IDLE: if (rx_prev && !rx_s) begin
                    rx_state <= START;
                    rx_tmr   <= HALF_RELOAD;
                end
                START: if (rx_done) begin
                    if (!rx_s) begin
                        rx_state <= DATA;
                        rx_tmr   <= BIT_RELOAD;
                        rx_bit   <= '0;
                    end else begin
                        rx_state <= IDLE;
                    end
                end
                DATA: if (rx_done) begin
                    rx_sh  <= {rx_s, rx_sh[7:1]};
                    rx_tmr <= BIT_RELOAD;
                    if (rx_bit == 3'd7)
                        rx_state <= STOP;
                    else
                        rx_bit <= rx_bit + 1'b1;
                end
                STOP: if (rx_done) begin
                    rx_state <= IDLE;
                    if (!rx_s)
                        rx_frame_err <= 1'b1;
                    else if (!rx_push)
                        rx_overrun <= 1'b1;
                end
                default: rx_state <= IDLE;
            endcase
        end
    end

    // ---------------- RX FIFO (fallthrough) ----------------
    always_ff @(posedge clk) begin
        if (rx_push)
            rx_mem[rx_wr] <= rx_sh;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_wr  <= '0;
            rx_rd  <= '0;
            rx_cnt <= '0;
        end else begin
            if (rx_push)
                rx_wr <= rx_wr + 1'b1;
            if (rx_pop)
                rx_rd <= rx_rd + 1'b1;
            if (rx_push && !rx_pop)
                rx_cnt <= rx_cnt + 1'b1;
            else if (!rx_push && rx_pop)
                rx_cnt <= rx_cnt - 1'b1;
        end
    end

    assign io_i_valid = (rx_cnt != '0);
    assign io_i_data  = rx_mem[rx_rd];

endmodule

// File: tb/tb_io_uart_bridge.sv
// Bench for io_uart_bridge at CLK_DIV=4, FIFO_DEPTH=4: frame tables, loopback,
// overrun/glitch/framing corners, reset abort and a randomized loopback run.
module tb_io_uart_bridge;
    localparam int DIV   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * DIV;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] io_o_data;
    logic       io_o_valid;
    logic       io_o_ready;
    logic [7:0] io_i_data;
    logic       io_i_valid;
    logic       io_i_ready;
    logic       uart_txd;
    logic       uart_rxd;
    logic       rx_overrun;
    logic       rx_frame_err;
    logic       loop_en = 1'b0;
    logic       rxd_drv = 1'b1;

    assign uart_rxd = loop_en ? uart_txd : rxd_drv;

    always #5 clk = ~clk;

    io_uart_bridge #(.CLK_DIV(DIV), .FIFO_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .io_o_data    (io_o_data),
        .io_o_valid   (io_o_valid),
        .io_o_ready   (io_o_ready),
        .io_i_data    (io_i_data),
        .io_i_valid   (io_i_valid),
        .io_i_ready   (io_i_ready),
        .uart_txd     (uart_txd),
        .uart_rxd     (uart_rxd),
        .rx_overrun   (rx_overrun),
        .rx_frame_err (rx_frame_err)
    );

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;   // bit 9 goes on the wire first
    } vec_t;

    int         checks = 0;
    int         errors = 0;
    int         ovr_cnt = 0;
    int         ferr_cnt = 0;
    logic [7:0] sent_q[$];
    logic [7:0] got_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Logs the handshakes that will complete on the coming edge, then samples pulses.
    task automatic cyc();
        if (io_o_valid && io_o_ready) sent_q.push_back(io_o_data);
        if (io_i_valid && io_i_ready) got_q.push_back(io_i_data);
        @(negedge clk);
        if (rx_overrun)   ovr_cnt++;
        if (rx_frame_err) ferr_cnt++;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc();
    endtask

    function automatic logic frame_bit(input logic [7:0] d, input int i);
        if (i == 0) return 1'b0;
        if (i == 9) return 1'b1;
        return d[i-1];
    endfunction

    task automatic send_serial(input logic [7:0] d, input logic stop);
        for (int i = 0; i < 10; i++) begin
            rxd_drv = (i == 9) ? stop : frame_bit(d, i);
            repeat (DIV) cyc();
        end
        rxd_drv = 1'b1;
    endtask

    initial begin
        vec_t       vecs[5];
        logic [7:0] b[6];
        logic       seen_full;
        logic       txd_all;
        int         n;

        vecs[0] = '{8'hA5, 10'b0101001011};
        vecs[1] = '{8'h3C, 10'b0001111001};
        vecs[2] = '{8'h00, 10'b0000000001};
        vecs[3] = '{8'hFF, 10'b0111111111};
        vecs[4] = '{8'h81, 10'b0100000011};

        io_o_data  = '0;
        io_o_valid = 1'b0;
        io_i_ready = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_txd", uart_txd, 1);
        chk("rst_o_ready", io_o_ready, 0);
        chk("rst_i_valid", io_i_valid, 0);
        chk("rst_overrun", rx_overrun, 0);
        chk("rst_frame_err", rx_frame_err, 0);
        rst = 1'b0;
        cyc();
        chk("ready_first_edge", io_o_ready, 1);

        // Table: idle-path frames with exact bit timing, looped back into RX
        loop_en    = 1'b1;
        io_i_ready = 1'b1;
        idle(4);
        foreach (vecs[v]) begin
            sent_q.delete();
            got_q.delete();
            io_o_data  = vecs[v].data;
            io_o_valid = 1'b1;
            cyc();
            io_o_valid = 1'b0;
            chk("tx_before_start", uart_txd, 1);
            for (int j = 0; j < FRAME; j++) begin
                cyc();
                chk("tx_frame_bit", uart_txd, vecs[v].frame[9 - j / DIV]);
            end
            for (int w = 0; w < 40 && got_q.size() == 0; w++) cyc();
            chk("rx_loop_count", got_q.size(), 1);
            if (got_q.size() > 0) chk("rx_loop_data", got_q[0], vecs[v].data);
            idle(8);
        end
        chk("table_overrun", ovr_cnt, 0);
        chk("table_frame_err", ferr_cnt, 0);

        // Six bytes held valid: ready drops at 4 queued, frames back-to-back
        loop_en = 1'b0;
        idle(4);
        foreach (b[i]) b[i] = 8'($urandom);
        sent_q.delete();
        seen_full = 1'b0;
        for (int c = 0; c < 6 * FRAME + 8; c++) begin
            io_o_valid = (sent_q.size() < 6);
            io_o_data  = (sent_q.size() < 6) ? b[sent_q.size()] : 8'h00;
            cyc();
            if (!io_o_ready && !seen_full) begin
                seen_full = 1'b1;
                chk("queued_at_full", sent_q.size() - 1, DEPTH);
            end
            if (c >= 1 && c - 1 < 6 * FRAME)
                chk("b2b_bit", uart_txd, frame_bit(b[(c-1) / FRAME], ((c-1) % FRAME) / DIV));
        end
        io_o_valid = 1'b0;
        chk("b2b_saw_full", seen_full, 1);
        chk("b2b_accepted", sent_q.size(), 6);
        chk("b2b_idle_after", uart_txd, 1);

        // Five looped frames with the core stalled: four held, one overrun
        loop_en    = 1'b1;
        io_i_ready = 1'b0;
        idle(4);
        ovr_cnt  = 0;
        ferr_cnt = 0;
        sent_q.delete();
        got_q.delete();
        for (int c = 0; c < 5 * FRAME + 80; c++) begin
            io_o_valid = (sent_q.size() < 5);
            io_o_data  = (sent_q.size() < 5) ? b[sent_q.size()] : 8'h00;
            cyc();
        end
        io_o_valid = 1'b0;
        chk("ovr_pulses", ovr_cnt, 1);
        chk("ovr_frame_err", ferr_cnt, 0);
        chk("ovr_valid_held", io_i_valid, 1);
        io_i_ready = 1'b1;
        idle(10);
        chk("ovr_drain_count", got_q.size(), DEPTH);
        for (int i = 0; i < DEPTH && i < got_q.size(); i++)
            chk("ovr_drain_order", got_q[i], b[i]);
        chk("ovr_drained_empty", io_i_valid, 0);

        // Glitch, bad stop bit, then a good frame on the raw serial input
        loop_en  = 1'b0;
        idle(4);
        ovr_cnt  = 0;
        ferr_cnt = 0;
        got_q.delete();
        rxd_drv = 1'b0;
        cyc();
        rxd_drv = 1'b1;
        idle(20);
        chk("glitch_no_byte", got_q.size(), 0);
        chk("glitch_no_ferr", ferr_cnt, 0);
        chk("glitch_no_ovr", ovr_cnt, 0);
        send_serial(8'h5A, 1'b0);
        idle(20);
        chk("ferr_pulses", ferr_cnt, 1);
        chk("ferr_no_byte", got_q.size(), 0);
        chk("ferr_fifo_empty", io_i_valid, 0);
        send_serial(8'hC3, 1'b1);
        idle(20);
        chk("recover_count", got_q.size(), 1);
        if (got_q.size() > 0) chk("recover_data", got_q[0], 8'hC3);
        chk("recover_ferr", ferr_cnt, 1);

        // Reset during TX data bit 3 with more bytes queued behind it
        sent_q.delete();
        for (int k = 0; k < 3; k++) begin
            io_o_data  = 8'h00;
            io_o_valid = 1'b1;
            cyc();
        end
        io_o_valid = 1'b0;
        repeat (16) cyc();
        chk("bit3_low", uart_txd, 0);
        rst = 1'b1;
        #1;
        chk("rst_txd_async", uart_txd, 1);
        chk("rst_ready_async", io_o_ready, 0);
        @(negedge clk);
        chk("rst_ready_held", io_o_ready, 0);
        chk("rst_i_valid_held", io_i_valid, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        got_q.delete();
        txd_all = 1'b1;
        for (int c = 0; c < 80; c++) begin
            cyc();
            txd_all = txd_all & uart_txd;
        end
        chk("post_rst_no_frame", txd_all, 1);
        chk("post_rst_ready", io_o_ready, 1);
        chk("post_rst_no_rx", got_q.size(), 0);

        // Randomized loopback: every accepted byte comes back once, in order
        loop_en  = 1'b1;
        ovr_cnt  = 0;
        ferr_cnt = 0;
        sent_q.delete();
        got_q.delete();
        for (int c = 0; c < 2000; c++) begin
            io_o_valid = ($urandom_range(0, 3) == 0);
            io_o_data  = 8'($urandom);
            io_i_ready = ($urandom_range(0, 3) != 0);
            cyc();
        end
        io_o_valid = 1'b0;
        io_i_ready = 1'b1;
        for (int w = 0; w < 600 && got_q.size() < sent_q.size(); w++) cyc();
        idle(60);
        chk("rand_count", got_q.size(), sent_q.size());
        n = (got_q.size() < sent_q.size()) ? got_q.size() : sent_q.size();
        for (int i = 0; i < n; i++)
            chk("rand_byte", got_q[i], sent_q[i]);
        chk("rand_overrun", ovr_cnt, 0);
        chk("rand_frame_err", ferr_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
